// File: rtl/cen_mean_accumulator.sv
// Block-mean accumulator feeding the whitening-stage centering divider.
// Sums 2**LOG2_N signed samples on four channels and pulses sum_valid for one
// cycle when the block is complete; the divider's >>> LOG2_N yields the mean.
// Optional macro CEN_ACC_ROUND_EN: preload the accumulators with 2**(LOG2_N-1)
// so the downstream shift rounds half-up instead of flooring.
module cen_mean_accumulator #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned LOG2_N = 7,
  localparam int unsigned SUM_W = DATA_W + LOG2_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x1,
  input  logic signed [DATA_W-1:0] x2,
  input  logic signed [DATA_W-1:0] x3,
  input  logic signed [DATA_W-1:0] x4,
  output logic signed [SUM_W-1:0]  sum1,
  output logic signed [SUM_W-1:0]  sum2,
  output logic signed [SUM_W-1:0]  sum3,
  output logic signed [SUM_W-1:0]  sum4,
  output logic                     sum_valid,
  output logic                     busy
);

`ifdef CEN_ACC_ROUND_EN
  // Half an LSB of the mean, so truncation by the divider becomes round-half-up.
  localparam logic [SUM_W-1:0] Init = SUM_W'(1) << (LOG2_N - 1);
`else
  localparam logic [SUM_W-1:0] Init = '0;
`endif

  // Count value of the last sample in a block (N-1).
  localparam logic [LOG2_N-1:0] LastCnt = '1;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e                   state_q, state_d;
  logic [3:0][SUM_W-1:0]    acc_q, acc_d;
  logic [LOG2_N-1:0]        cnt_q, cnt_d;
  logic                     in_ready_q, in_ready_d;
  logic                     sum_valid_q, sum_valid_d;
  logic                     busy_q, busy_d;
  logic [3:0][DATA_W-1:0]   x_all;

  assign x_all = {x4, x3, x2, x1};

  // Next-state, accumulate and registered-output decode.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    sum_valid_d = 1'b0;
    busy_d      = busy_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StAccum;
          acc_d      = {4{Init}};
          cnt_d      = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      StAccum: begin
        // start is deliberately ignored here: no restart mid-block.
        if (in_valid && in_ready_q) begin
          for (int k = 0; k < 4; k++) begin
            acc_d[k] = acc_q[k] + {{LOG2_N{x_all[k][DATA_W-1]}}, x_all[k]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d     = StDone;
            in_ready_d  = 1'b0;
            sum_valid_d = 1'b1;
          end
        end
      end
      StDone: begin
        // A start seen here is dropped; the producer reissues it in idle.
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d    = StIdle;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      sum_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      sum_valid_q <= sum_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Sums are the accumulator registers themselves; they hold until the next start.
  assign sum1      = acc_q[0];
  assign sum2      = acc_q[1];
  assign sum3      = acc_q[2];
  assign sum4      = acc_q[3];
  assign in_ready  = in_ready_q;
  assign sum_valid = sum_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cen_mean_accumulator.sv
// Scoreboard bench for cen_mean_accumulator: the driver pushes hand-computed block
// sums when a block is issued, the monitor pops and compares on each sum_valid.
module tb_cen_mean_accumulator;

  localparam int DataW = 14;
  localparam int Log2N = 7;
  localparam int SumW  = 21;
`ifdef CEN_ACC_ROUND_EN
  localparam int TbInit = 64;
`else
  localparam int TbInit = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [DataW-1:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0;
  logic signed [SumW-1:0]  sum1, sum2, sum3, sum4;
  logic                    sum_valid;
  logic                    busy;

  typedef struct {
    int s1;
    int s2;
    int s3;
    int s4;
    int mean;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  cen_mean_accumulator #(
    .DATA_W(DataW),
    .LOG2_N(Log2N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x1       (x1),
    .x2       (x2),
    .x3       (x3),
    .x4       (x4),
    .sum1     (sum1),
    .sum2     (sum2),
    .sum3     (sum3),
    .sum4     (sum4),
    .sum_valid(sum_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // Monitor: every sum_valid cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && sum_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sum_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum1", int'(sum1), mon_e.s1);
        check("sum2", int'(sum2), mon_e.s2);
        check("sum3", int'(sum3), mon_e.s3);
        check("sum4", int'(sum4), mon_e.s4);
        check("mean1", int'(sum1 >>> Log2N), mon_e.mean);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int s1, input int s2, input int s3, input int s4,
                          input int mean);
    exp_t e;
    e.s1 = s1 + TbInit;
    e.s2 = s2 + TbInit;
    e.s3 = s3 + TbInit;
    e.s4 = s4 + TbInit;
    e.mean = mean;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("in_ready_after_start", int'(in_ready), 1);
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    check("in_ready_on_send", int'(in_ready), 1);
    x1 = DataW'(a);
    x2 = DataW'(b);
    x3 = DataW'(c);
    x4 = DataW'(d);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the edge that accepted the last sample.
  task automatic end_block(input int s1_hold);
    check("sum_valid_after_last", int'(sum_valid), 1);
    check("busy_in_done", int'(busy), 1);
    check("in_ready_in_done", int'(in_ready), 0);
    tick();
    check("sum_valid_one_cycle", int'(sum_valid), 0);
    check("busy_back_idle", int'(busy), 0);
    tick();
    check("sum1_held", int'(sum1), s1_hold + TbInit);
  endtask

  task automatic check_reset_state();
    check("rst_sum1", int'(sum1), 0);
    check("rst_sum2", int'(sum2), 0);
    check("rst_sum3", int'(sum3), 0);
    check("rst_sum4", int'(sum4), 0);
    check("rst_sum_valid", int'(sum_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_reset_state();

    // 1: all ones; a sample offered alongside start must be dropped.
    push_exp(128, 128, 128, 128, 1);
    x1 = 14'sd100; x2 = 14'sd100; x3 = 14'sd100; x4 = 14'sd100;
    in_valid = 1'b1;
    do_start();
    in_valid = 1'b0;
    for (int i = 0; i < 128; i++) send(1, 1, 1, 1);
    end_block(128);

    // 2: extreme values, alternating sign, ramp.
    push_exp(1048448, -1048576, 0, 8128, 8191);
    do_start();
    for (int i = 0; i < 128; i++) send(8191, -8192, (i % 2 == 0) ? 100 : -100, i);
    end_block(1048448);

    // 3: in_valid gap on every third cycle.
    push_exp(128, 128, 128, 128, 1);
    do_start();
    begin
      int c = 0;
      int n = 0;
      while (n < 128) begin
        if (c % 3 == 2) tick();
        else begin
          send(1, 1, 1, 1);
          n++;
        end
        c++;
      end
    end
    end_block(128);

    // 4: reset mid-block abandons it with no pulse, then a clean block of twos.
    do_start();
    for (int i = 0; i < 60; i++) send(1, 1, 1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state();
    push_exp(256, 256, 256, 256, 2);
    do_start();
    for (int i = 0; i < 128; i++) send(2, 2, 2, 2);
    end_block(256);

    // 5: start during accumulation and during done is ignored.
    push_exp(384, 384, 384, 384, 3);
    do_start();
    for (int i = 0; i < 128; i++) begin
      start = (i == 50);
      send(3, 3, 3, 3);
    end
    start = 1'b0;
    check("sum_valid_s5", int'(sum_valid), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_dropped_busy", int'(busy), 0);
    check("start_in_done_dropped_ready", int'(in_ready), 0);
    tick();
    check("still_idle_busy", int'(busy), 0);
    check("s5_sum4_held", int'(sum4), 384 + TbInit);

    // 6: all minus one (-128 floor, -64 when rounding); mean is -1 either way.
    push_exp(-128, -128, -128, -128, -1);
    do_start();
    for (int i = 0; i < 128; i++) send(-1, -1, -1, -1);
    end_block(-128);

    tick();
    tick();
    check("all_blocks_seen", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
